vram_arbiter: RTL and testbench

Single-port video RAM arbiter sharing one synchronous-read BSRAM between the display scanout fetch (hard real-time, fixed priority) and the Z8 SoC CPU bus (req/ack handshake, read and write). Sits in the `hdmi_clk` domain between the display timing/pixel path and the `VideoRAM` storage array. Owns all RAM port signals and sequences every access.

---
 rtl/vram_pkg.sv | 30 +++
 rtl/vram_write_buffer.sv | 53 +++++
 rtl/vram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared encodings and default widths for the video RAM arbiter.
// Consumed by vram_arbiter and vram_write_buffer.
package vram_pkg;

    localparam int VRAM_ADDR_BITS = 13;
    localparam int VRAM_DATA_BITS = 8;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_WAIT = 2'd1,
        C_ACK  = 2'd2
    } cpu_state_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_CPU  = 2'd2
    } vram_tag_e;

    // Video and CPU issues are mutually exclusive; video is checked first anyway.
    function automatic vram_tag_e issue_tag(input logic vid, input logic cpu);
        if (vid) begin
            return TAG_VID;
        end else if (cpu) begin
            return TAG_CPU;
        end
        return TAG_NONE;
    endfunction

endpackage

// File: rtl/vram_write_buffer.sv
// One-entry posted write buffer (address, data, full flag).
// Only instantiated when VRAM_ARB_POSTED_WRITE_EN is defined.
module vram_write_buffer
    import vram_pkg::*;
#(
    parameter int ADDR_BITS = VRAM_ADDR_BITS,
    parameter int DATA_BITS = VRAM_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 drain_i,
    output logic                 full_o,
    output logic [ADDR_BITS-1:0] addr_o,
    output logic [DATA_BITS-1:0] data_o
);

    logic                 full_q, full_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        addr_d = addr_q;
        data_d = data_q;
        if (load_i && !full_q) begin
            full_d = 1'b1;
            addr_d = addr_i;
            data_d = data_i;
        end else if (drain_i && full_q) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: scanout fetch (fixed priority, pipelined) vs CPU req/ack.
// Optional posted CPU writes under VRAM_ARB_POSTED_WRITE_EN.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_BITS = VRAM_ADDR_BITS,
    parameter int DATA_BITS = VRAM_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vidReq,
    input  logic [ADDR_BITS-1:0] vidAddr,
    output logic [DATA_BITS-1:0] vidData,
    output logic                 vidValid,
    input  logic                 cpuReq,
    input  logic                 cpuWe,
    input  logic [ADDR_BITS-1:0] cpuAddr,
    input  logic [DATA_BITS-1:0] cpuWData,
    output logic [DATA_BITS-1:0] cpuRData,
    output logic                 cpuAck,
    output logic                 ramEn,
    output logic                 ramWe,
    output logic [ADDR_BITS-1:0] ramAddr,
    output logic [DATA_BITS-1:0] ramWData,
    input  logic [DATA_BITS-1:0] ramRData
);

`ifdef VRAM_ARB_POSTED_WRITE_EN
    localparam bit POSTED_WRITE = 1'b1;
`else
    localparam bit POSTED_WRITE = 1'b0;
`endif

    cpu_state_e           cstate_q, cstate_d;
    vram_tag_e            tag_a_q, tag_b_q;
    logic                 cpu_we_q;
    logic                 ram_en_q, ram_we_q;
    logic [ADDR_BITS-1:0] ram_addr_q;
    logic [DATA_BITS-1:0] ram_wdata_q;
    logic                 vid_valid_q, cpu_ack_q;
    logic [DATA_BITS-1:0] vid_data_q, cpu_rdata_q;

    logic                 vid_issue, cpu_issue, wb_load, wb_drain;
    logic                 wb_full;
    logic [ADDR_BITS-1:0] wb_addr;
    logic [DATA_BITS-1:0] wb_data;

`ifdef VRAM_ARB_POSTED_WRITE_EN
    vram_write_buffer #(
        .ADDR_BITS(ADDR_BITS),
        .DATA_BITS(DATA_BITS)
    ) u_wbuf (
        .clk    (clk),
        .reset  (reset),
        .load_i (wb_load),
        .addr_i (cpuAddr),
        .data_i (cpuWData),
        .drain_i(wb_drain),
        .full_o (wb_full),
        .addr_o (wb_addr),
        .data_o (wb_data)
    );
`else
    assign wb_full = 1'b0;
    assign wb_addr = '0;
    assign wb_data = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cstate_q <= C_IDLE;
        end else begin
            cstate_q <= cstate_d;
        end
    end

    always_comb begin
        cstate_d = cstate_q;
        case (cstate_q)
            C_IDLE: begin
                if (cpu_issue) begin
                    cstate_d = C_WAIT;
                end else if (wb_load) begin
                    cstate_d = C_ACK;
                end
            end
            C_WAIT: begin
                if (tag_b_q == TAG_CPU) begin
                    cstate_d = C_ACK;
                end
            end
            C_ACK:   cstate_d = C_IDLE;
            default: cstate_d = C_IDLE;
        endcase
    end

    // A full buffer blocks every new CPU request so a later read cannot overtake the write.
    always_comb begin
        vid_issue = vidReq;
        wb_drain  = POSTED_WRITE && wb_full && !vidReq;
        wb_load   = 1'b0;
        cpu_issue = 1'b0;
        if (cstate_q == C_IDLE && cpuReq && !wb_full) begin
            if (POSTED_WRITE && cpuWe) begin
                wb_load = 1'b1;
            end else if (!vidReq) begin
                cpu_issue = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            tag_a_q     <= TAG_NONE;
            tag_b_q     <= TAG_NONE;
            cpu_we_q    <= 1'b0;
        end else begin
            ram_en_q <= vid_issue | cpu_issue | wb_drain;
            ram_we_q <= (cpu_issue & cpuWe) | wb_drain;
            if (vid_issue) begin
                ram_addr_q <= vidAddr;
            end else if (cpu_issue) begin
                ram_addr_q  <= cpuAddr;
                ram_wdata_q <= cpuWData;
            end else if (wb_drain) begin
                ram_addr_q  <= wb_addr;
                ram_wdata_q <= wb_data;
            end
            tag_a_q <= issue_tag(vid_issue, cpu_issue);
            tag_b_q <= tag_a_q;
            if (cpu_issue) begin
                cpu_we_q <= cpuWe;
            end
        end
    end

    // tag_b_q marks the access whose read data is on ramRData this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vid_valid_q <= 1'b0;
            vid_data_q  <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            vid_valid_q <= (tag_b_q == TAG_VID);
            if (tag_b_q == TAG_VID) begin
                vid_data_q <= ramRData;
            end
            cpu_ack_q <= (tag_b_q == TAG_CPU) | wb_load;
            if (tag_b_q == TAG_CPU && !cpu_we_q) begin
                cpu_rdata_q <= ramRData;
            end
        end
    end

    assign ramEn    = ram_en_q;
    assign ramWe    = ram_we_q;
    assign ramAddr  = ram_addr_q;
    assign ramWData = ram_wdata_q;
    assign vidValid = vid_valid_q;
    assign vidData  = vid_data_q;
    assign cpuAck   = cpu_ack_q;
    assign cpuRData = cpu_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized traffic against a memory-level model.
module tb_vram_arbiter;

    localparam int AW = 13;
    localparam int DW = 8;
`ifdef VRAM_ARB_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          vidReq, cpuReq, cpuWe;
    logic [AW-1:0] vidAddr, cpuAddr, ramAddr;
    logic [DW-1:0] vidData, cpuWData, cpuRData, ramWData, ramRData;
    logic          vidValid, cpuAck, ramEn, ramWe;

    vram_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW)) dut (
        .clk(clk), .reset(reset),
        .vidReq(vidReq), .vidAddr(vidAddr), .vidData(vidData), .vidValid(vidValid),
        .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
        .cpuRData(cpuRData), .cpuAck(cpuAck),
        .ramEn(ramEn), .ramWe(ramWe), .ramAddr(ramAddr), .ramWData(ramWData),
        .ramRData(ramRData)
    );

    always #5 clk = ~clk;

    // Synchronous-read BSRAM attached to the arbiter.
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ramEn) begin
            if (ramWe) ram_mem[ramAddr] = ramWData;
            else       ramRData <= ram_mem[ramAddr];
        end
    end

    // Reference model state: expected memory contents and expected output timeline.
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    bit            rv [0:7];
    logic [DW-1:0] rd [0:7];
    int            cyc = 0;
    int            exp_ack = -1;
    bit            exp_we;
    logic [DW-1:0] exp_rdata, last_rd;
    bit            cpu_wait = 1'b0;
    bit            wb_full_m = 1'b0;
    int            tests = 0;
    int            fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) rv[i] = 1'b0;
        exp_ack   = -1;
        wb_full_m = 1'b0;
        last_rd   = '0;
        cpu_wait  = cpuReq;
    endtask

    // One clock: predict from the inputs presented at this edge, then check outputs 1 ns after it.
    task automatic tick();
        bit load_m;
        cyc++;
        load_m = 1'b0;
        if (vidReq) begin
            rv[(cyc + 2) % 8] = 1'b1;
            rd[(cyc + 2) % 8] = shadow[vidAddr];
        end
        if (cpuReq && cpu_wait) begin
            if (POSTED && cpuWe) begin
                if (!wb_full_m) begin
                    load_m = 1'b1; exp_ack = cyc; exp_we = 1'b1; cpu_wait = 1'b0;
                    shadow[cpuAddr] = cpuWData;
                end
            end else if (!wb_full_m && !vidReq) begin
                exp_ack = cyc + 2; exp_we = cpuWe; cpu_wait = 1'b0;
                if (cpuWe) shadow[cpuAddr] = cpuWData;
                else       exp_rdata = shadow[cpuAddr];
            end
        end
        if (wb_full_m && !vidReq) wb_full_m = 1'b0;
        if (load_m) wb_full_m = 1'b1;
        @(posedge clk);
        #1;
        check("vid_valid", {31'b0, vidValid}, {31'b0, rv[cyc % 8]});
        if (rv[cyc % 8]) check("vid_data", {24'b0, vidData}, {24'b0, rd[cyc % 8]});
        rv[cyc % 8] = 1'b0;
        check("cpu_ack", {31'b0, cpuAck}, {31'b0, cyc == exp_ack});
        if (cyc == exp_ack) begin
            if (!exp_we) last_rd = exp_rdata;
            check("cpu_rdata", {24'b0, cpuRData}, {24'b0, last_rd});
        end
    endtask

    task automatic drive_vid(input int pct);
        vidReq  = ($urandom_range(99) < pct);
        vidAddr = AW'($urandom_range(255));
    endtask

    task automatic wait_ack(input int vid_pct);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            drive_vid(vid_pct);
            tick();
            got = cpuAck;
        end
        check("cpu_ack_seen", {31'b0, got}, 32'd1);
        cpuReq = 1'b0;
        vidReq = 1'b0;
        tick();
    endtask

    task automatic cpu_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input int vid_pct);
        cpuReq = 1'b1; cpuWe = we; cpuAddr = addr; cpuWData = data; cpu_wait = 1'b1;
        wait_ack(vid_pct);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vidValid"}, {31'b0, vidValid}, 32'd0);
        check({tag, "_cpuAck"},   {31'b0, cpuAck},   32'd0);
        check({tag, "_ramEn"},    {31'b0, ramEn},    32'd0);
        check({tag, "_ramWe"},    {31'b0, ramWe},    32'd0);
        check({tag, "_ramAddr"},  {19'b0, ramAddr},  32'd0);
        check({tag, "_ramWData"}, {24'b0, ramWData}, 32'd0);
        check({tag, "_vidData"},  {24'b0, vidData},  32'd0);
        check({tag, "_cpuRData"}, {24'b0, cpuRData}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v;
        reset = 1'b1;
        vidReq = 1'b0; vidAddr = '0;
        cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWData = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            v = (i < 256) ? DW'($urandom) : '0;
            ram_mem[i] = v;
            shadow[i]  = v;
        end
        ram_mem[0] = 8'h11; ram_mem[1] = 8'h22; ram_mem[2] = 8'h33; ram_mem[3] = 8'h44;
        shadow[0]  = 8'h11; shadow[1]  = 8'h22; shadow[2]  = 8'h33; shadow[3]  = 8'h44;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        model_reset();
        reset = 1'b0;
        tick();

        // Video only: four back-to-back fetches
        for (int i = 0; i < 4; i++) begin
            vidReq = 1'b1; vidAddr = AW'(i);
            tick();
        end
        vidReq = 1'b0;
        repeat (3) tick();

        // CPU write then read back
        cpu_op(1'b1, 13'h1234, 8'hA5, 0);
        cpu_op(1'b0, 13'h1234, 8'h00, 0);
        check("readback_a5", {24'b0, cpuRData}, 32'h0000_00A5);

        // Same-edge conflict: video first, CPU one edge later
        vidReq = 1'b1; vidAddr = 13'h0010;
        cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 13'h0020; cpu_wait = 1'b1;
        tick();
        check("conflict_ram_en0", {31'b0, ramEn}, 32'd1);
        check("conflict_ram_addr0", {19'b0, ramAddr}, 32'h0010);
        vidReq = 1'b0;
        tick();
        check("conflict_ram_en1", {31'b0, ramEn}, 32'd1);
        check("conflict_ram_addr1", {19'b0, ramAddr}, 32'h0020);
        wait_ack(0);

        // Starvation then recovery
        cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 13'h1234; cpu_wait = 1'b1;
        for (int i = 0; i < 10; i++) begin
            vidReq = 1'b1; vidAddr = AW'(16 + i);
            tick();
        end
        vidReq = 1'b0;
        wait_ack(0);

        // Reset between CPU issue and ack, request held through release
        cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 13'h1234; cpu_wait = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        model_reset();
        #1;
        reset = 1'b0;
        wait_ack(0);

`ifdef VRAM_ARB_POSTED_WRITE_EN
        // Posted write under continuous video traffic
        vidReq = 1'b1; vidAddr = 13'h0050;
        cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 13'h0100; cpuWData = 8'h5A; cpu_wait = 1'b1;
        tick();
        check("posted_ack", {31'b0, cpuAck}, 32'd1);
        cpuReq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("posted_no_early_write", {31'b0, ramWe}, 32'd0);
        end
        vidReq = 1'b0;
        tick();
        check("posted_drain_we", {31'b0, ramEn & ramWe}, 32'd1);
        check("posted_drain_addr", {19'b0, ramAddr}, 32'h0100);
        check("posted_drain_data", {24'b0, ramWData}, 32'h005A);
        tick();
        cpu_op(1'b0, 13'h0100, 8'h00, 0);
        check("posted_readback", {24'b0, cpuRData}, 32'h0000_005A);
`endif

        // Randomized mixed traffic
        for (int n = 0; n < 40; n++) begin
            cpu_op(1'($urandom_range(1)), AW'(13'h1000 + $urandom_range(31)), DW'($urandom), 50);
        end
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
